stopwatch_sequencer: RTL and testbench
======================================

Name: stopwatch_sequencer

Overview:
- Replacement top-level sequencer for the stopwatch datapath.
- Consumes one-shot button pulses (start/stop, lap, clear) and the watch-register end flag.
- Generates the watch-register load strobes, the tick prescaler that paces BCD increment/decrement, and lap-freeze control for the display mux.
- Runs on the 10 kHz system tick clock; all outputs registered.

Parameters:
- TICK_DIV, 100, clk cycles per watch update (10 kHz / 100 = 0.01 s resolution); legal range 2..1023.
- PRE_W, 10, prescaler counter width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  in  1  system tick clock (10 kHz)
- reset_n  in  1  asynchronous active-low reset
- start_stop  in  1  one-cycle pulse, start/stop request
- lap  in  1  one-cycle pulse, lap freeze/release request
- clear  in  1  one-cycle pulse, reload initial watch value
- count_down  in  1  watch direction (1 = decrement); sampled each cycle
- is_end  in  1  watch register at terminal value (9999 up / 0000 down)
- tick_en  out  1  one-cycle strobe: load next BCD into watch register
- load_init  out  1  one-cycle strobe: load reset-mux value into watch register
- lap_capture  out  1  one-cycle strobe: copy watch into lap register
- show_lap  out  1  display source select (1 = lap register)
- done  out  1  high while in DONE
- state  out  3  current state encoding, for debug LEDs

Behaviour:
- States: INIT=0, IDLE=1, RUN=2, LAP=3, PAUSED=4, DONE=5; codes 6–7 go to INIT next cycle.
- Reset (async, reset_n=0): state=INIT, prescaler=0, all outputs 0. Mid-operation reset aborts immediately; no strobe is issued during reset.
- INIT: load_init=1 for exactly one cycle, then IDLE.
- Input priority each cycle: clear > start_stop > lap.
  - clear in any state: next state INIT, prescaler=0, show_lap=0.
  - Simultaneous start_stop+lap: lap is ignored.
- IDLE:
  - start_stop with is_end=0: go to RUN.
  - start_stop with is_end=1: stay IDLE.
  - lap: ignored.
- RUN/LAP:
  - Prescaler increments each cycle and wraps at TICK_DIV-1.
  - On the wrap cycle with is_end=0: tick_en=1.
  - On the wrap cycle with is_end=1: no tick, go to DONE.
  - is_end on non-wrap cycles is not acted upon.
- Latency: start_stop pulse at cycle n gives state RUN at n+1; first tick_en at cycle n+TICK_DIV.
- RUN + lap: lap_capture=1 for one cycle, show_lap=1, go to LAP.
- LAP + lap: show_lap=0, go to RUN; no capture.
- RUN or LAP + start_stop: go to PAUSED, show_lap=0.
- PAUSED:
  - Prescaler holds its value, so a partial period is preserved.
  - start_stop: go to RUN.
  - lap: ignored.
- DONE:
  - done=1, prescaler=0.
  - start_stop and lap ignored; only clear or reset leaves DONE.
- Strobe exclusivity: tick_en, load_init and lap_capture are mutually exclusive in any cycle. A cycle with a clear request produces no tick.

Optional Feature:
- Macro: STOPWATCH_AUTO_RELOAD_EN.
- Defined: in RUN/LAP, a wrap cycle with is_end=1 and count_down=1 asserts load_init (not tick_en) and keeps the current state; a countdown timer repeats indefinitely. Count-up end still goes to DONE.
- Undefined: every end goes to DONE. The count_down input is unused apart from lint tie-off.

Decomposition:
- Package stopwatch_pkg:
  - state encodings and STATE_W=3;
  - default TICK_DIV constant;
  - terminal BCD constants 16'h9999 and 16'h0000 (shared with end logic).
- Sub-module tick_prescaler:
  - PRE_W-bit counter with enable, synchronous clear and wrap output;
  - instantiated once.

Test Plan (TICK_DIV=4):
- Release reset: load_init high exactly one cycle at first edge, then state=1, all other outputs 0.
- start_stop at cycle 10, is_end=0: state=2 at cycle 11; tick_en at cycles 14, 18, 22.
- RUN, lap at a cycle between ticks: lap_capture one cycle, show_lap=1, tick_en continues every 4 cycles. Second lap: show_lap=0, no capture.
- Pause after 2 prescaler counts, hold 20 cycles, resume: next tick_en occurs 2 cycles after resume.
- count_down=1, is_end raised before a wrap:
  - without macro: no tick, state=5, done=1, start_stop ignored; clear gives INIT then IDLE;
  - with macro: load_init at wrap, state stays 2.
- Simultaneous clear+start_stop while RUN gives INIT; reset_n pulsed low mid-RUN clears all outputs asynchronously within the same cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the stopwatch sequencer slice.
// Feature macro used by this slice: STOPWATCH_AUTO_RELOAD_EN.
package stopwatch_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_RUN    = 3'd2,
        S_LAP    = 3'd3,
        S_PAUSED = 3'd4,
        S_DONE   = 3'd5
    } stateT;

    localparam int DEFAULT_TICK_DIV = 100;

    // Terminal watch values; the external end logic compares against these.
    localparam logic [15:0] BCD_UP_END   = 16'h9999;
    localparam logic [15:0] BCD_DOWN_END = 16'h0000;

endpackage

// File: rtl/stopwatch_sequencer_tick_prescaler.sv
// Period counter pacing watch updates: counts 0..TICK_DIV-1 while enabled.
// 'wrap' flags the terminal count, so an enabled cycle with wrap high rolls to zero.
module tick_prescaler #(
    parameter int TICK_DIV = 100,
    parameter int PRE_W    = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    logic [PRE_W-1:0] count;

    assign wrap = (count == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Top-level stopwatch sequencer: button pulses in, registered watch-register strobes out.
// Define STOPWATCH_AUTO_RELOAD_EN to make a countdown reload and repeat instead of stopping.
module stopwatch_sequencer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int PRE_W    = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_stop,
    input  logic         lap,
    input  logic         clear,
    input  logic         count_down,
    input  logic         is_end,
    output logic         tick_en,
    output logic         load_init,
    output logic         lap_capture,
    output logic         show_lap,
    output logic         done,
    output logic [2:0]   state
);

    stateT curState, nextState;
    logic  counting, atTerm, preClr;
    logic  tickNext, loadNext, capNext;

`ifndef STOPWATCH_AUTO_RELOAD_EN
    logic unusedCountDown;
    assign unusedCountDown = count_down;
`endif

    // The entering edge into RUN already counts, so the first tick lands TICK_DIV cycles after the request.
    always_comb begin
        nextState = curState;
        counting  = 1'b0;
        tickNext  = 1'b0;
        loadNext  = 1'b0;
        capNext   = 1'b0;
        if (clear) begin
            nextState = S_INIT;
        end else begin
            case (curState)
                S_INIT: begin
                    nextState = S_IDLE;
                    loadNext  = 1'b1;
                end
                S_IDLE: begin
                    if (start_stop && !is_end) begin
                        nextState = S_RUN;
                        counting  = 1'b1;
                    end
                end
                S_RUN, S_LAP: begin
                    if (start_stop) begin
                        nextState = S_PAUSED;
                    end else begin
                        counting = 1'b1;
                        if (lap && curState == S_LAP) begin
                            nextState = S_RUN;
                        end else if (lap && !atTerm) begin
                            nextState = S_LAP;
                            capNext   = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (start_stop) begin
                        nextState = S_RUN;
                        counting  = 1'b1;
                    end
                end
                S_DONE: begin
                    nextState = S_DONE;
                end
                default: begin
                    nextState = S_INIT;
                end
            endcase

            // A lap request landing on a wrap is dropped above so capture never collides with a tick.
            if (counting && atTerm) begin
                if (!is_end) begin
                    tickNext = 1'b1;
                end else begin
`ifdef STOPWATCH_AUTO_RELOAD_EN
                    if (count_down) begin
                        loadNext = 1'b1;
                    end else begin
                        nextState = S_DONE;
                    end
`else
                    nextState = S_DONE;
`endif
                end
            end
        end
    end

    assign preClr = (nextState == S_INIT) || (nextState == S_IDLE) || (nextState == S_DONE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) uPrescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (counting),
        .clr     (preClr),
        .wrap    (atTerm)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            curState    <= S_INIT;
            tick_en     <= 1'b0;
            load_init   <= 1'b0;
            lap_capture <= 1'b0;
            show_lap    <= 1'b0;
            done        <= 1'b0;
        end else begin
            curState    <= nextState;
            tick_en     <= tickNext;
            load_init   <= loadNext;
            lap_capture <= capNext;
            show_lap    <= (nextState == S_LAP);
            done        <= (nextState == S_DONE);
        end
    end

    assign state = curState;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer with TICK_DIV=4.
// Expectation for the end scenario follows STOPWATCH_AUTO_RELOAD_EN when defined.
module tb_stopwatch_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       startStop, lapIn, clearIn, countDown, isEnd;
    logic       tickEn, loadInit, lapCapture, showLap, done;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    stopwatch_sequencer #(
        .TICK_DIV (4),
        .PRE_W    (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_stop  (startStop),
        .lap         (lapIn),
        .clear       (clearIn),
        .count_down  (countDown),
        .is_end      (isEnd),
        .tick_en     (tickEn),
        .load_init   (loadInit),
        .lap_capture (lapCapture),
        .show_lap    (showLap),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        startStop = 0; lapIn = 0; clearIn = 0; countDown = 0; isEnd = 0;
        step(3);
        checks++;
        if ({state, tickEn, loadInit, lapCapture, showLap, done} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got state=%0d outs=%b required state=0 outs=00000",
                     state, {tickEn, loadInit, lapCapture, showLap, done});
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (loadInit !== 1'b1 || state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL reset_first_edge: got load_init=%b state=%0d required 1/1", loadInit, state);
        end
        step(1);
        checks++;
        if ({state, tickEn, loadInit, lapCapture, showLap, done} !== {3'd1, 5'b0}) begin
            errors++;
            $display("[TB] FAIL reset_idle: got state=%0d outs=%b required state=1 outs=00000",
                     state, {tickEn, loadInit, lapCapture, showLap, done});
        end
    endtask

    // After the start pulse, ticks appear at offsets 3, 7, 11 from the first RUN cycle.
    task automatic test_run;
        startStop = 1; step(1); startStop = 0;
        checks++;
        if (state !== 3'd2 || tickEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_entry: got state=%0d tick=%b required 2/0", state, tickEn);
        end
        for (int k = 1; k <= 11; k++) begin
            step(1);
            checks++;
            if (tickEn !== ((k % 4) == 3) || loadInit !== 1'b0 || state !== 3'd2) begin
                errors++;
                $display("[TB] FAIL run_tick[%0d]: got tick=%b load=%b state=%0d required tick=%b load=0 state=2",
                         k, tickEn, loadInit, state, ((k % 4) == 3));
            end
        end
    endtask

    task automatic test_lap;
        lapIn = 1; step(1); lapIn = 0;
        checks++;
        if (lapCapture !== 1'b1 || showLap !== 1'b1 || state !== 3'd3 || tickEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lap_enter: got cap=%b show=%b state=%0d tick=%b required 1/1/3/0",
                     lapCapture, showLap, state, tickEn);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if (lapCapture !== 1'b0 || showLap !== 1'b1 || tickEn !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL lap_hold[%0d]: got cap=%b show=%b tick=%b required 0/1/%b",
                         k, lapCapture, showLap, tickEn, (k == 3));
            end
        end
        lapIn = 1; step(1); lapIn = 0;
        checks++;
        if (lapCapture !== 1'b0 || showLap !== 1'b0 || state !== 3'd2) begin
            errors++;
            $display("[TB] FAIL lap_release: got cap=%b show=%b state=%0d required 0/0/2",
                     lapCapture, showLap, state);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if (tickEn !== (k == 3) || lapCapture !== 1'b0) begin
                errors++;
                $display("[TB] FAIL lap_after[%0d]: got tick=%b cap=%b required %b/0",
                         k, tickEn, lapCapture, (k == 3));
            end
        end
    endtask

    // Pause two counts into a period; on resume the remaining two counts produce the tick.
    task automatic test_pause;
        int seenTick;
        seenTick = 0;
        step(2);
        startStop = 1; step(1); startStop = 0;
        checks++;
        if (state !== 3'd4 || tickEn !== 1'b0 || showLap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_enter: got state=%0d tick=%b show=%b required 4/0/0", state, tickEn, showLap);
        end
        lapIn = 1; step(1); lapIn = 0;
        for (int k = 0; k < 19; k++) begin
            if (tickEn) seenTick++;
            step(1);
        end
        checks++;
        if (seenTick != 0 || state !== 3'd4 || lapCapture !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_hold: got ticks=%0d state=%0d cap=%b required 0/4/0", seenTick, state, lapCapture);
        end
        startStop = 1; step(1); startStop = 0;
        checks++;
        if (state !== 3'd2 || tickEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL resume_entry: got state=%0d tick=%b required 2/0", state, tickEn);
        end
        step(1);
        checks++;
        if (tickEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resume_tick: got tick=%b required 1", tickEn);
        end
        step(4);
        checks++;
        if (tickEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resume_period: got tick=%b required 1", tickEn);
        end
    endtask

    task automatic test_end;
        countDown = 1;
        step(2);
        isEnd = 1;
        step(1);
        checks++;
        if (state !== 3'd2 || done !== 1'b0 || tickEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL end_nonwrap: got state=%0d done=%b tick=%b required 2/0/0", state, done, tickEn);
        end
        step(1);
`ifdef STOPWATCH_AUTO_RELOAD_EN
        checks++;
        if (loadInit !== 1'b1 || tickEn !== 1'b0 || state !== 3'd2 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL end_reload: got load=%b tick=%b state=%0d done=%b required 1/0/2/0",
                     loadInit, tickEn, state, done);
        end
`else
        checks++;
        if (state !== 3'd5 || done !== 1'b1 || tickEn !== 1'b0 || loadInit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL end_done: got state=%0d done=%b tick=%b load=%b required 5/1/0/0",
                     state, done, tickEn, loadInit);
        end
        startStop = 1; step(1); startStop = 0;
        lapIn = 1; step(1); lapIn = 0;
        checks++;
        if (state !== 3'd5 || done !== 1'b1 || lapCapture !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_ignore: got state=%0d done=%b cap=%b required 5/1/0", state, done, lapCapture);
        end
`endif
        clearIn = 1; step(1); clearIn = 0;
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || tickEn !== 1'b0 || loadInit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_init: got state=%0d done=%b tick=%b load=%b required 0/0/0/0",
                     state, done, tickEn, loadInit);
        end
        step(1);
        checks++;
        if (state !== 3'd1 || loadInit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_idle: got state=%0d load=%b required 1/1", state, loadInit);
        end
        startStop = 1; step(1); startStop = 0;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL idle_at_end: got state=%0d required 1", state);
        end
        isEnd = 0; countDown = 0;
    endtask

    task automatic test_back_to_back;
        startStop = 1; step(1); startStop = 0;
        step(1);
        clearIn = 1; startStop = 1; step(1); clearIn = 0; startStop = 0;
        checks++;
        if (state !== 3'd0 || tickEn !== 1'b0 || loadInit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_priority: got state=%0d tick=%b load=%b required 0/0/0", state, tickEn, loadInit);
        end
        step(1);
        startStop = 1; lapIn = 1; step(1); startStop = 0; lapIn = 0;
        step(1);
        lapIn = 1; startStop = 1; step(1); lapIn = 0; startStop = 0;
        checks++;
        if (state !== 3'd4 || lapCapture !== 1'b0 || showLap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_over_lap: got state=%0d cap=%b show=%b required 4/0/0", state, lapCapture, showLap);
        end
        startStop = 1; step(1); startStop = 0;
        lapIn = 1; step(1); lapIn = 0;
        reset_n = 1'b0;
        #2;
        checks++;
        if ({state, tickEn, loadInit, lapCapture, showLap, done} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got state=%0d outs=%b required state=0 outs=00000",
                     state, {tickEn, loadInit, lapCapture, showLap, done});
        end
        reset_n = 1'b1;
        step(1);
        checks++;
        if (state !== 3'd1 || loadInit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_recover: got state=%0d load=%b required 1/1", state, loadInit);
        end
    endtask

    initial begin
        test_reset;
        test_run;
        test_lap;
        test_pause;
        test_end;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
